tmr_count_down: RTL
===================

Name: tmr_count_down

Overview:
- Countdown timer core for the digital clock's Timer mode, built as the down-counting counterpart of the stopwatch up-counters.
- Holds an hours:minutes:seconds value loaded from the set-time path and decrements it on each 1 Hz tick.
- Raises a one-cycle expiry pulse and a held alarm request for the buzzer/display logic.
- Sits between the 1 Hz tick generator and the display mux/buzzer driver.

Parameters:
- MAX_HR, 99, largest loadable hours value; larger loads clamp to MAX_HR.
- HR_W, 8, width of the hours field and output.

Ports:
- CLK  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick_1hz  in  1  one-cycle count-enable pulse, once per second.
- load  in  1  capture preset_hr/min/sec.
- preset_hr  in  HR_W  preset hours.
- preset_min  in  8  preset minutes.
- preset_sec  in  8  preset seconds.
- start  in  1  begin or resume counting.
- pause  in  1  freeze counting.
- clear  in  1  abort and zero everything.
- alarm_ack  in  1  user acknowledge of expiry.
- hrs  out  HR_W  current hours.
- mins  out  8  current minutes.
- secs  out  8  current seconds.
- running  out  1  high in RUN.
- expired  out  1  one-cycle pulse at expiry.
- alarm  out  1  held high in DONE.

Behaviour:
- Reset (async, rst_n low): hrs, mins and secs are 0, state IDLE, and running, expired and alarm are 0. Reset mid-count aborts with no expired pulse.
- FSM states: IDLE, ARMED, RUN, PAUSE, DONE. Encoding lives in the package.
- Per-cycle priority: clear > load > pause > start > tick_1hz.
- clear (any state): counters go to 0, state goes to IDLE, alarm drops the next cycle.
- load is accepted in IDLE, ARMED, PAUSE and DONE, and ignored in RUN.
  - Preset_min or preset_sec above 59 clamps to 59. Preset_hr above MAX_HR clamps to MAX_HR.
  - A nonzero clamped preset goes to ARMED. An all-zero preset goes to IDLE.
  - A load in DONE also drops alarm.
- start: ARMED->RUN and PAUSE->RUN. Ignored in IDLE, RUN and DONE.
- pause: RUN->PAUSE. Ignored in all other states.
- tick_1hz is honoured only in RUN. The decrement is registered and updates on the cycle after the tick.
  - secs>0: secs-1.
  - secs==0: secs=59 with a borrow into mins. mins==0 gives mins=59 with a borrow into hrs, and hrs decrements.
  - No wrap below 00:00:00. The value never underflows because RUN exits on reaching zero.
- Expiry: when a tick in RUN takes the value from 00:00:01 to 00:00:00, the next state is DONE.
  - expired is a registered pulse, high for exactly the first cycle in DONE.
  - alarm goes high on the same edge and stays high until alarm_ack, clear or load.
  - alarm_ack in DONE moves to IDLE, and alarm drops the next cycle.
- running is 1 iff the state is RUN. Outputs are registered with no combinational path from inputs.
- Simultaneous events:
  - pause and tick in RUN: pause wins and the value is unchanged.
  - start and tick in ARMED: enter RUN, and that tick is not counted.
  - load and start together: load wins and start is ignored that cycle.

Optional Feature:
- Macro: TMR_AUTO_RELOAD_EN.
- With it defined: the clamped preset is kept in a shadow register. Expiry still pulses expired and sets alarm, but the counters reload the shadow value on the same edge and the state stays RUN (repeat timer). alarm_ack clears alarm without leaving RUN, and pause/clear work as normal.
- Without it: there is no shadow register and expiry enters DONE as described in Behaviour.

Decomposition:
- Shared package tmr_pkg holds the state typedef/encoding (IDLE, ARMED, RUN, PAUSE, DONE) and the constants SEC_MAX=59 and MIN_MAX=59.
- One sub-module, tmr_borrow_digit, is instantiated twice (secs, mins): an 8-bit mod-(MAX+1) down counter with load, clamp, dec_en and borrow_out (value==0 && dec_en).
- The hours field and the FSM stay in the top level.

Test Plan:
- Reset during RUN at 00:01:30 -> all outputs 0, state IDLE, no expired pulse.
- load 00:00:03, start, 3 ticks -> secs 2,1,0; expired pulses once on the cycle after the 3rd tick; alarm stays 1 until alarm_ack, then 0.
- load 01:00:00, start, 1 tick -> 00:59:59 (double borrow); load 00:75:80 -> clamped to 00:59:59.
- RUN at 00:00:10, pause and tick in the same cycle -> value unchanged. 5 further ticks in PAUSE -> unchanged. start then tick -> 00:00:09.
- load 00:00:00 then start -> stays IDLE, running 0. load during RUN -> ignored.
- With TMR_AUTO_RELOAD_EN: preset 00:00:02 expires -> expired pulse, value reloads to 00:00:02 and running stays 1. clear -> 00:00:00, IDLE.

Source files
------------

// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmr_pkg
// Purpose  : Shared state encoding, field limits and a clamp helper for the
//            countdown timer core.
// Revision : 1.0 - initial release
// ============================================================================
package tmr_pkg;

  // Timer control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } tmr_state_t;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

  // Saturate an 8-bit field at the given maximum.
  function automatic logic [7:0] clamp8(input logic [7:0] val, input logic [7:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_borrow_digit.sv
`default_nettype none
// ============================================================================
// Module   : tmr_borrow_digit
// Purpose  : 8-bit mod-(MAX+1) down counter with clamped load. Counting down
//            from zero wraps to MAX and raises borrow for the next field.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_borrow_digit
  import tmr_pkg::*;
#(
  parameter logic [7:0] MAX = 8'd59
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec_en,
  output logic [7:0] o_value,
  output logic       o_borrow
);

  logic [7:0] r_value;
  logic [7:0] w_load_clamped;

  assign w_load_clamped = clamp8(i_load_val, MAX);

  // Field register: clear beats load beats decrement.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 8'd0;
    end else if (i_clr) begin
      r_value <= 8'd0;
    end else if (i_load) begin
      r_value <= w_load_clamped;
    end else if (i_dec_en) begin
      r_value <= (r_value == 8'd0) ? MAX : (r_value - 8'd1);
    end
  end

  assign o_value  = r_value;
  assign o_borrow = (r_value == 8'd0) && i_dec_en;

endmodule
`default_nettype wire

// File: rtl/tmr_count_down.sv
`default_nettype none
// ============================================================================
// Module   : tmr_count_down
// Purpose  : hh:mm:ss countdown timer with expiry pulse and held alarm.
//            Optional macro TMR_AUTO_RELOAD_EN turns it into a repeat timer
//            that reloads the last preset on expiry and keeps running.
// Revision : 1.0 - initial release
// ============================================================================
module tmr_count_down
  import tmr_pkg::*;
#(
  parameter int MAX_HR = 99,
  parameter int HR_W   = 8
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            tick_1hz,
  input  logic            load,
  input  logic [HR_W-1:0] preset_hr,
  input  logic [7:0]      preset_min,
  input  logic [7:0]      preset_sec,
  input  logic            start,
  input  logic            pause,
  input  logic            clear,
  input  logic            alarm_ack,
  output logic [HR_W-1:0] hrs,
  output logic [7:0]      mins,
  output logic [7:0]      secs,
  output logic            running,
  output logic            expired,
  output logic            alarm
);

  localparam logic [HR_W-1:0] c_max_hr = HR_W'(MAX_HR);

  tmr_state_t      r_state;
  tmr_state_t      w_state_nxt;
  logic [HR_W-1:0] r_hrs;
  logic [HR_W-1:0] w_hr_clamped;
  logic [HR_W-1:0] w_rl_hr;
  logic [7:0]      w_min;
  logic [7:0]      w_sec;
  logic [7:0]      w_rl_min;
  logic [7:0]      w_rl_sec;
  logic            w_load_ok;
  logic            w_preset_nz;
  logic            w_tick_take;
  logic            w_expire;
  logic            w_reload;
  logic            w_sec_borrow;
  logic            w_min_borrow;
  logic            r_running;
  logic            r_expired;
  logic            r_alarm;

  // Load is ignored while running; clear outranks everything. Clamping never
  // turns a nonzero field into zero, so the raw preset decides ARMED vs IDLE.
  assign w_load_ok    = !clear && load && (r_state != ST_RUN);
  assign w_preset_nz  = (preset_hr != '0) || (preset_min != 8'd0) || (preset_sec != 8'd0);
  assign w_hr_clamped = (preset_hr > c_max_hr) ? c_max_hr : preset_hr;
  assign w_tick_take  = !clear && !pause && tick_1hz && (r_state == ST_RUN);
  assign w_expire     = w_tick_take && (r_hrs == '0) && (w_min == 8'd0) && (w_sec == 8'd1);

`ifdef TMR_AUTO_RELOAD_EN
  logic [HR_W-1:0] r_sh_hr;
  logic [7:0]      r_sh_min;
  logic [7:0]      r_sh_sec;

  // Shadow copy of the last accepted (clamped) preset for repeat mode.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hr  <= '0;
      r_sh_min <= 8'd0;
      r_sh_sec <= 8'd0;
    end else if (w_load_ok) begin
      r_sh_hr  <= w_hr_clamped;
      r_sh_min <= clamp8(preset_min, MIN_MAX);
      r_sh_sec <= clamp8(preset_sec, SEC_MAX);
    end
  end

  assign w_reload = w_expire;
  assign w_rl_hr  = r_sh_hr;
  assign w_rl_min = r_sh_min;
  assign w_rl_sec = r_sh_sec;
`else
  assign w_reload = 1'b0;
  assign w_rl_hr  = '0;
  assign w_rl_min = 8'd0;
  assign w_rl_sec = 8'd0;
`endif

  tmr_borrow_digit #(.MAX(SEC_MAX)) u_sec (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .i_clr      (clear),
    .i_load     (w_load_ok | w_reload),
    .i_load_val (w_load_ok ? preset_sec : w_rl_sec),
    .i_dec_en   (w_tick_take),
    .o_value    (w_sec),
    .o_borrow   (w_sec_borrow)
  );

  tmr_borrow_digit #(.MAX(MIN_MAX)) u_min (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .i_clr      (clear),
    .i_load     (w_load_ok | w_reload),
    .i_load_val (w_load_ok ? preset_min : w_rl_min),
    .i_dec_en   (w_sec_borrow),
    .o_value    (w_min),
    .o_borrow   (w_min_borrow)
  );

  // Hours field: takes the borrow out of minutes; never goes below zero.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_hrs <= '0;
    end else if (clear) begin
      r_hrs <= '0;
    end else if (w_load_ok) begin
      r_hrs <= w_hr_clamped;
    end else if (w_reload) begin
      r_hrs <= w_rl_hr;
    end else if (w_min_borrow && (r_hrs != '0)) begin
      r_hrs <= r_hrs - HR_W'(1);
    end
  end

  // Next-state decode: clear, then load, then per-state pause/start/expiry.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load_ok) begin
      w_state_nxt = w_preset_nz ? ST_ARMED : ST_IDLE;
    end else begin
      case (r_state)
        ST_ARMED, ST_PAUSE: if (start) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (pause)                      w_state_nxt = ST_PAUSE;
          else if (w_expire && !w_reload) w_state_nxt = ST_DONE;
        end
        ST_DONE: if (alarm_ack) w_state_nxt = ST_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State register plus registered status outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= w_expire;
      if (clear || w_load_ok) r_alarm <= 1'b0;
      else if (w_expire)      r_alarm <= 1'b1;
      else if (alarm_ack)     r_alarm <= 1'b0;
    end
  end

  assign hrs     = r_hrs;
  assign mins    = w_min;
  assign secs    = w_sec;
  assign running = r_running;
  assign expired = r_expired;
  assign alarm   = r_alarm;

endmodule
`default_nettype wire
